// File: rtl/conv_pkg.sv
// Shared definitions for the conv layer datapath: FSM states, width helpers and
// the output clamp that the pooling stage also uses.
package conv_pkg;

  typedef enum logic [1:0] {
    ST_LOAD_W = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

  // Wide enough that a full window of products never overflows.
  function automatic int acc_width(input int dw, input int ww, input int n);
    return dw + ww + clog2(n) + 1;
  endfunction

  function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] v,
                                                   input int ow);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    else if (v < lo) return lo;
    else return v;
  endfunction

endpackage

// File: rtl/conv_mac_stage.sv
// Two-stage multiply/accumulate: registered product, then an accumulator that
// restarts on the first beat of a window; exposes the biased sum.
module conv_mac_stage #(
  parameter int DATA_WIDTH   = 15,
  parameter int WEIGHT_WIDTH = 8,
  parameter int BIAS_WIDTH   = 8,
  parameter int ACC_WIDTH    = 28
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    issue_i,
  input  logic                    first_i,
  input  logic [WEIGHT_WIDTH-1:0] weight_i,
  input  logic [DATA_WIDTH-1:0]   data_i,
  input  logic [BIAS_WIDTH-1:0]   bias_i,
  output logic [ACC_WIDTH:0]      sum_o
);

  localparam int PW = DATA_WIDTH + WEIGHT_WIDTH;

  logic [PW-1:0]        dx_s;
  logic [PW-1:0]        wx_s;
  logic [PW-1:0]        prod_q;
  logic                 pvld_q;
  logic                 pfirst_q;
  logic [ACC_WIDTH-1:0] acc_q;
  logic [ACC_WIDTH-1:0] prod_ext_s;

  // Both operands widened to the full product width so the low bits are exact.
  assign dx_s       = {{WEIGHT_WIDTH{data_i[DATA_WIDTH-1]}}, data_i};
  assign wx_s       = {{DATA_WIDTH{weight_i[WEIGHT_WIDTH-1]}}, weight_i};
  assign prod_ext_s = {{(ACC_WIDTH-PW){prod_q[PW-1]}}, prod_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q   <= '0;
      pvld_q   <= 1'b0;
      pfirst_q <= 1'b0;
      acc_q    <= '0;
    end else begin
      pvld_q   <= issue_i;
      pfirst_q <= first_i;
      if (issue_i) prod_q <= dx_s * wx_s;
      if (pvld_q) acc_q <= pfirst_q ? prod_ext_s : acc_q + prod_ext_s;
    end
  end

  assign sum_o = {acc_q[ACC_WIDTH-1], acc_q}
               + {{(ACC_WIDTH+1-BIAS_WIDTH){bias_i[BIAS_WIDTH-1]}}, bias_i};

endmodule

// File: rtl/conv_dot_mac.sv
// Kernel dot-product engine: weight bank, beat counter, handshake FSM and the
// registered result; arithmetic lives in conv_mac_stage.
module conv_dot_mac
  import conv_pkg::*;
#(
  parameter int KERNEL_SIZE  = 3,
  parameter int CHANNELS     = 4,
  parameter int DATA_WIDTH   = 15,
  parameter int WEIGHT_WIDTH = 8,
  parameter int BIAS_WIDTH   = 8,
  parameter int OUT_WIDTH    = 30,
  parameter bit SATURATE     = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    w_valid,
  output logic                    w_ready,
  input  logic [WEIGHT_WIDTH-1:0] w_data,
  input  logic [BIAS_WIDTH-1:0]   bias,
  input  logic                    w_reload,
  input  logic                    d_valid,
  output logic                    d_ready,
  input  logic [DATA_WIDTH-1:0]   d_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUT_WIDTH-1:0]    out_data,
  output logic                    done,
  output logic                    weights_ok
);

  localparam int N   = KERNEL_SIZE * CHANNELS;
  localparam int CW  = (clog2(N) > 0) ? clog2(N) : 1;
  localparam int ACC = acc_width(DATA_WIDTH, WEIGHT_WIDTH, N);

  logic [WEIGHT_WIDTH-1:0] bank_q [N];
  logic [BIAS_WIDTH-1:0]   bias_q;
  logic [CW-1:0]           cnt_q;
  state_e                  state_q;
  logic                    drain_q, pend_q;
  logic                    w_ready_q, d_ready_q, out_valid_q, done_q, wok_q;
  logic [OUT_WIDTH-1:0]    out_data_q;
  logic                    w_hs_s, d_hs_s, o_hs_s, last_s;
  logic [ACC:0]            sum_s;
  logic [63:0]             sum_ext_s;
  logic [OUT_WIDTH-1:0]    out_d;

  assign w_hs_s = w_valid & w_ready_q;
  assign d_hs_s = d_valid & d_ready_q;
  assign o_hs_s = out_valid_q & out_ready;
  assign last_s = (cnt_q == CW'(N - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) bank_q[i] <= '0;
      bias_q <= '0;
    end else if (w_hs_s) begin
      bank_q[cnt_q] <= w_data;
      if (cnt_q == '0) bias_q <= bias;
    end
  end

  conv_mac_stage #(
    .DATA_WIDTH  (DATA_WIDTH),
    .WEIGHT_WIDTH(WEIGHT_WIDTH),
    .BIAS_WIDTH  (BIAS_WIDTH),
    .ACC_WIDTH   (ACC)
  ) u_mac (
    .clk     (clk),
    .rst     (rst),
    .issue_i (d_hs_s),
    .first_i (cnt_q == '0),
    .weight_i(bank_q[cnt_q]),
    .data_i  (d_data),
    .bias_i  (bias_q),
    .sum_o   (sum_s)
  );

  assign sum_ext_s = {{(64-ACC-1){sum_s[ACC]}}, sum_s};

  always_comb begin
    out_d = '0;
    out_d = OUT_WIDTH'(SATURATE ? sat_clamp(sum_ext_s, OUT_WIDTH) : sum_ext_s);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_LOAD_W;
      cnt_q       <= '0;
      drain_q     <= 1'b0;
      pend_q      <= 1'b0;
      w_ready_q   <= 1'b0;
      d_ready_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
      wok_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_LOAD_W: begin
          w_ready_q <= 1'b1;
          d_ready_q <= 1'b0;
          if (w_hs_s) begin
            if (last_s) begin
              cnt_q     <= '0;
              wok_q     <= 1'b1;
              w_ready_q <= 1'b0;
              d_ready_q <= 1'b1;
              state_q   <= ST_RUN;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        // An accepted beat wins over a same-cycle reload; the reload then waits for the result.
        ST_RUN: begin
          if (d_hs_s) begin
            if (w_reload) pend_q <= 1'b1;
            if (last_s) begin
              cnt_q     <= '0;
              d_ready_q <= 1'b0;
              drain_q   <= 1'b0;
              state_q   <= ST_DRAIN;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end else if (w_reload && cnt_q == '0) begin
            wok_q     <= 1'b0;
            w_ready_q <= 1'b1;
            d_ready_q <= 1'b0;
            pend_q    <= 1'b0;
            state_q   <= ST_LOAD_W;
          end else if (w_reload) begin
            pend_q <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (w_reload) pend_q <= 1'b1;
          if (drain_q) begin
            out_valid_q <= 1'b1;
            out_data_q  <= out_d;
            state_q     <= ST_HOLD;
          end else begin
            drain_q <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (o_hs_s) begin
            out_valid_q <= 1'b0;
            done_q      <= 1'b1;
            if (w_reload || pend_q) begin
              wok_q     <= 1'b0;
              w_ready_q <= 1'b1;
              pend_q    <= 1'b0;
              state_q   <= ST_LOAD_W;
            end else begin
              d_ready_q <= 1'b1;
              state_q   <= ST_RUN;
            end
          end else if (w_reload) begin
            pend_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_LOAD_W;
          cnt_q       <= '0;
          w_ready_q   <= 1'b0;
          d_ready_q   <= 1'b0;
          out_valid_q <= 1'b0;
          wok_q       <= 1'b0;
        end
      endcase
    end
  end

  assign w_ready    = w_ready_q;
  assign d_ready    = d_ready_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign done       = done_q;
  assign weights_ok = wok_q;

endmodule

// File: tb/tb_conv_dot_mac.sv
// Directed bench: instance 0 is K=3,C=2 wrapping at 30 bits, instance 1 is
// K=3,C=1 saturating at 16 bits.
module tb_conv_dot_mac;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        w_valid [2];
  logic        w_reload[2];
  logic        d_valid [2];
  logic        out_ready[2];
  logic [7:0]  w_data  [2];
  logic [7:0]  bias    [2];
  logic [14:0] d_data  [2];
  logic        w_ready [2];
  logic        d_ready [2];
  logic        out_valid[2];
  logic        done    [2];
  logic        weights_ok[2];
  logic [29:0] out0;
  logic [15:0] out1;
  int          vecs = 0;
  int          miscmp = 0;

  always #5 clk = ~clk;

  conv_dot_mac #(.KERNEL_SIZE(3), .CHANNELS(2), .OUT_WIDTH(30), .SATURATE(1'b0)) dut0 (
    .clk(clk), .rst(rst), .w_valid(w_valid[0]), .w_ready(w_ready[0]), .w_data(w_data[0]),
    .bias(bias[0]), .w_reload(w_reload[0]), .d_valid(d_valid[0]), .d_ready(d_ready[0]),
    .d_data(d_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_data(out0), .done(done[0]), .weights_ok(weights_ok[0]));

  conv_dot_mac #(.KERNEL_SIZE(3), .CHANNELS(1), .OUT_WIDTH(16), .SATURATE(1'b1)) dut1 (
    .clk(clk), .rst(rst), .w_valid(w_valid[1]), .w_ready(w_ready[1]), .w_data(w_data[1]),
    .bias(bias[1]), .w_reload(w_reload[1]), .d_valid(d_valid[1]), .d_ready(d_ready[1]),
    .d_data(d_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_data(out1), .done(done[1]), .weights_ok(weights_ok[1]));

  function automatic longint outv(input int id);
    if (id == 0) return longint'($signed(out0));
    else return longint'($signed(out1));
  endfunction

  task automatic chk(input string tag, input longint obs, input longint exp);
    vecs++;
    assert (obs === exp) else begin
      miscmp++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic load(input int id, input int n, input int wv[6], input int b);
    int g;
    for (int i = 0; i < n; i++) begin
      w_valid[id] = 1'b1;
      w_data[id]  = 8'(wv[i]);
      bias[id]    = 8'(b);
      g = 0;
      while (w_ready[id] !== 1'b1 && g < 40) begin @(negedge clk); g++; end
      if (g >= 40) chk("w_ready_timeout", 0, 1);
      @(negedge clk);
    end
    w_valid[id] = 1'b0;
  endtask

  task automatic feed(input int id, input int n, input int dv[6], input bit gaps,
                      input int reload_at);
    int g;
    for (int i = 0; i < n; i++) begin
      if (i == reload_at) w_reload[id] = 1'b1;
      if (gaps && (i % 2 == 1)) begin
        d_valid[id] = 1'b0;
        @(negedge clk);
      end
      d_valid[id] = 1'b1;
      d_data[id]  = 15'(dv[i]);
      g = 0;
      while (d_ready[id] !== 1'b1 && g < 40) begin @(negedge clk); g++; end
      if (g >= 40) chk("d_ready_timeout", 0, 1);
      @(negedge clk);
    end
    d_valid[id] = 1'b0;
  endtask

  // Entered one cycle after the last data handshake; result must appear two cycles later.
  task automatic expect_result(input int id, input longint exp, input string tag);
    int lat;
    chk({tag, "_drain_d_ready"}, longint'(d_ready[id]), 0);
    lat = 1;
    while (out_valid[id] !== 1'b1 && lat < 12) begin @(negedge clk); lat++; end
    chk({tag, "_latency"}, lat, 3);
    chk({tag, "_data"}, outv(id), exp);
  endtask

  task automatic accept(input int id, input bit to_load);
    out_ready[id] = 1'b1;
    @(negedge clk);
    out_ready[id] = 1'b0;
    chk("done_pulse", longint'(done[id]), 1);
    chk("out_valid_clr", longint'(out_valid[id]), 0);
    if (to_load) begin
      chk("reload_w_ready", longint'(w_ready[id]), 1);
      chk("reload_wok", longint'(weights_ok[id]), 0);
    end else begin
      chk("d_ready_back", longint'(d_ready[id]), 1);
    end
    @(negedge clk);
    chk("done_single", longint'(done[id]), 0);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      w_valid[i] = 1'b0; w_reload[i] = 1'b0; d_valid[i] = 1'b0; out_ready[i] = 1'b0;
      w_data[i] = 8'd0; bias[i] = 8'd0; d_data[i] = 15'd0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_w_ready", longint'(w_ready[i]), 0);
      chk("rst_d_ready", longint'(d_ready[i]), 0);
      chk("rst_out_valid", longint'(out_valid[i]), 0);
      chk("rst_done", longint'(done[i]), 0);
      chk("rst_wok", longint'(weights_ok[i]), 0);
      chk("rst_out_data", outv(i), 0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("w_ready_rise0", longint'(w_ready[0]), 1);
    chk("w_ready_rise1", longint'(w_ready[1]), 1);

    // K=3,C=1: 2*10 - 3*20 + 4*30 + 5 = 85
    load(1, 3, '{2, -3, 4, 0, 0, 0}, 5);
    chk("k3c1_wok", longint'(weights_ok[1]), 1);
    chk("k3c1_d_ready", longint'(d_ready[1]), 1);
    feed(1, 3, '{10, 20, 30, 0, 0, 0}, 1'b0, -1);
    expect_result(1, 85, "k3c1");
    accept(1, 1'b0);

    // Immediate reload at cnt=0, then saturate high and low.
    w_reload[1] = 1'b1;
    @(negedge clk);
    w_reload[1] = 1'b0;
    chk("imm_reload_wok", longint'(weights_ok[1]), 0);
    chk("imm_reload_w_ready", longint'(w_ready[1]), 1);
    chk("imm_reload_d_ready", longint'(d_ready[1]), 0);
    load(1, 3, '{127, 127, 127, 0, 0, 0}, 0);
    feed(1, 3, '{16383, 16383, 16383, 0, 0, 0}, 1'b0, -1);
    expect_result(1, 32767, "sat_hi");
    accept(1, 1'b0);
    w_reload[1] = 1'b1;
    @(negedge clk);
    w_reload[1] = 1'b0;
    load(1, 3, '{-128, -128, -128, 0, 0, 0}, 0);
    feed(1, 3, '{16383, 16383, 16383, 0, 0, 0}, 1'b0, -1);
    expect_result(1, -32768, "sat_lo");
    accept(1, 1'b0);

    // K=3,C=2 with gaps: 5+6+7-1-2-3 = 12, then hold under backpressure.
    load(0, 6, '{1, 1, 1, -1, -1, -1}, 0);
    feed(0, 6, '{5, 6, 7, 1, 2, 3}, 1'b1, -1);
    expect_result(0, 12, "k3c2");
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("bp_out_data", outv(0), 12);
      chk("bp_out_valid", longint'(out_valid[0]), 1);
      chk("bp_d_ready", longint'(d_ready[0]), 0);
    end
    accept(0, 1'b0);
    feed(0, 6, '{0, 0, 0, 0, 0, 0}, 1'b0, -1);
    expect_result(0, 0, "zeros");
    accept(0, 1'b0);

    // Reload raised at beat 1: old weights give 1+2+3-4-5-6 = -9, then LOAD_W.
    feed(0, 6, '{1, 2, 3, 4, 5, 6}, 1'b0, 1);
    expect_result(0, -9, "defer_reload");
    accept(0, 1'b1);
    w_reload[0] = 1'b0;

    // New weights 2 each, bias -1: 2*21 - 1 = 41.
    load(0, 6, '{2, 2, 2, 2, 2, 2}, -1);
    feed(0, 6, '{1, 2, 3, 4, 5, 6}, 1'b0, -1);
    expect_result(0, 41, "new_w");
    accept(0, 1'b0);

    // Reset while draining discards the window.
    feed(0, 6, '{1, 2, 3, 4, 5, 6}, 1'b0, -1);
    rst = 1'b1;
    @(negedge clk);
    chk("drst_out_valid", longint'(out_valid[0]), 0);
    chk("drst_out_data", outv(0), 0);
    chk("drst_w_ready", longint'(w_ready[0]), 0);
    chk("drst_d_ready", longint'(d_ready[0]), 0);
    chk("drst_wok", longint'(weights_ok[0]), 0);
    chk("drst_done", longint'(done[0]), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("drst_w_ready_rel", longint'(w_ready[0]), 1);
    repeat (4) @(negedge clk);
    chk("drst_no_result", longint'(out_valid[0]), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
    $finish;
  end

endmodule
